// File: rtl/midi_writer.sv
// midi_writer: serializes 2- or 3-byte MIDI channel messages onto a UART line
module midi_writer #(
  parameter int CYCLES_PER_BIT = 3200
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] status,
  input  logic [3:0] channel,
  input  logic [7:0] data_byte1,
  input  logic [7:0] data_byte2,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam logic [15:0] BIT_LAST = 16'(CYCLES_PER_BIT - 1);

  logic [1:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  shifter;
  logic [6:0]  d1;
  logic [6:0]  d2;
  logic        len3;
  logic        legal;
  logic        bit_end;

  assign legal   = status[3] && status != 4'hf;
  assign bit_end = bit_cnt == BIT_LAST;

  // Frame sequencer: the shifter holds the byte on the wire, LSB shifted out first
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      shifter     <= '0;
      d1          <= '0;
      d2          <= '0;
      len3        <= 1'b0;
      tx_wire_out <= 1'b1;
      ready_out   <= 1'b1;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;
      if (state != IDLE) bit_cnt <= bit_end ? '0 : bit_cnt + 16'd1;
      case (state)
        IDLE: if (valid_in) begin
          if (legal) begin
            state       <= START;
            tx_wire_out <= 1'b0;
            ready_out   <= 1'b0;
            busy_out    <= 1'b1;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            shifter     <= {status, channel};
            d1          <= data_byte1[6:0];
            d2          <= data_byte2[6:0];
            len3        <= status != 4'hc && status != 4'hd;
          end else error_out <= 1'b1;
        end
        START: if (bit_end) begin
          state       <= DATA;
          bit_idx     <= '0;
          tx_wire_out <= shifter[0];
          shifter     <= shifter >> 1;
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state       <= STOP;
            tx_wire_out <= 1'b1;
          end else begin
            bit_idx     <= bit_idx + 3'd1;
            tx_wire_out <= shifter[0];
            shifter     <= shifter >> 1;
          end
        end
        STOP: if (bit_end) begin
          if (byte_idx == (len3 ? 2'd2 : 2'd1)) begin
            state     <= IDLE;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b1;
          end else begin
            state       <= START;
            tx_wire_out <= 1'b0;
            byte_idx    <= byte_idx + 2'd1;
            shifter     <= {1'b0, byte_idx == 2'd0 ? d1 : d2};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_midi_writer.sv
// tb_midi_writer: directed stimulus with a UART-decoding scoreboard monitor
module tb_midi_writer;
  localparam int CPB = 4;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [3:0] status = '0;
  logic [3:0] channel = '0;
  logic [7:0] data_byte1 = '0;
  logic [7:0] data_byte2 = '0;
  logic       valid_in = 1'b0;
  logic       ready_out, tx_wire_out, busy_out, done_out, error_out;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  midi_writer #(.CYCLES_PER_BIT(CPB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .status(status), .channel(channel),
    .data_byte1(data_byte1), .data_byte2(data_byte2), .valid_in(valid_in),
    .ready_out(ready_out), .tx_wire_out(tx_wire_out), .busy_out(busy_out),
    .done_out(done_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (done_out) n_done <= n_done + 1;
    if (error_out) n_err <= n_err + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] s, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    status = s;
    channel = c;
    data_byte1 = a;
    data_byte2 = b;
    valid_in = 1'b1;
  endtask

  task automatic push_msg(input logic [3:0] s, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back({s, c});
    exp_q.push_back({1'b0, a[6:0]});
    if (s != 4'hc && s != 4'hd) exp_q.push_back({1'b0, b[6:0]});
  endtask

  task automatic accept(input string name, output int t0);
    @(posedge clk_in);
    #1;
    t0 = cyc;
    check({name, "_tx_latency"}, tx_wire_out, 0);
    check({name, "_ready_low"}, ready_out, 0);
    check({name, "_busy_high"}, busy_out, 1);
  endtask

  task automatic wait_done(input int t0, input int len, input string name);
    int k;
    logic busy_ok;
    k = 0;
    busy_ok = 1'b1;
    @(negedge clk_in);
    while (!done_out && k < 2000) begin
      if (!busy_out) busy_ok = 1'b0;
      @(negedge clk_in);
      k++;
    end
    check({name, "_done_seen"}, done_out, 1);
    check({name, "_duration"}, cyc - t0, len * 10 * CPB);
    check({name, "_busy_throughout"}, busy_ok, 1);
    check({name, "_ready_on_done"}, ready_out, 1);
    check({name, "_busy_low_on_done"}, busy_out, 0);
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic stp;
    logic ab;
    forever begin
      do @(negedge clk_in); while (tx_wire_out !== 1'b0 || !rst_n_in);
      ab = 1'b0;
      b = '0;
      stp = 1'b0;
      for (int c = 1; c < 10 * CPB; c++) begin
        @(negedge clk_in);
        if (!rst_n_in) begin
          ab = 1'b1;
          break;
        end
        if (c >= 6 && c <= 34 && c % 4 == 2) b[c/4-1] = tx_wire_out;
        if (c == 38) stp = tx_wire_out;
      end
      if (!ab) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none", b);
        end else check("byte", b, exp_q.pop_front());
        check("stop_bit", stp, 1);
      end
    end
  end

  initial begin : stim
    int t0, t1, e0, d0;
    logic ok_tx, ok_rdy;
    repeat (3) @(negedge clk_in);
    check("rst_tx", tx_wire_out, 1);
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_error", error_out, 0);
    // Note On accepted on the first edge after reset release
    rst_n_in = 1'b1;
    push_msg(4'h9, 4'h3, 8'h3c, 8'h64);
    set_in(4'h9, 4'h3, 8'h3c, 8'h64);
    accept("noteon", t0);
    valid_in = 1'b0;
    wait_done(t0, 3, "noteon");
    @(negedge clk_in);
    check("noteon_done_pulse", done_out, 0);
    // Program Change with data bit 7 set
    push_msg(4'hc, 4'h0, 8'h85, 8'h00);
    set_in(4'hc, 4'h0, 8'h85, 8'h00);
    accept("pgm", t0);
    valid_in = 1'b0;
    wait_done(t0, 2, "pgm");
    // Illegal status
    @(negedge clk_in);
    e0 = n_err;
    set_in(4'hf, 4'h1, 8'h12, 8'h34);
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    check("err_ready", ready_out, 1);
    @(negedge clk_in);
    check("err_pulse", error_out, 1);
    ok_tx = 1'b1;
    ok_rdy = 1'b1;
    repeat (50) begin
      @(negedge clk_in);
      if (tx_wire_out !== 1'b1) ok_tx = 1'b0;
      if (ready_out !== 1'b1) ok_rdy = 1'b0;
    end
    check("err_tx_idle", ok_tx, 1);
    check("err_ready_held", ok_rdy, 1);
    check("err_count", n_err - e0, 1);
    // Back-to-back with valid held and inputs changed after acceptance
    push_msg(4'h9, 4'h1, 8'h40, 8'h7f);
    set_in(4'h9, 4'h1, 8'h40, 8'h7f);
    accept("b2b_a", t0);
    push_msg(4'hc, 4'h5, 8'h12, 8'h00);
    set_in(4'hc, 4'h5, 8'h12, 8'h00);
    wait_done(t0, 3, "b2b_a");
    accept("b2b_b", t1);
    valid_in = 1'b0;
    wait_done(t1, 2, "b2b_b");
    // Reset during DATA of the second byte
    @(negedge clk_in);
    push_msg(4'h9, 4'h7, 8'h11, 8'h22);
    set_in(4'h9, 4'h7, 8'h11, 8'h22);
    accept("abort", t0);
    valid_in = 1'b0;
    while (cyc < t0 + 50) @(negedge clk_in);
    d0 = n_done;
    rst_n_in = 1'b0;
    #1;
    check("abort_tx_high", tx_wire_out, 1);
    check("abort_busy_low", busy_out, 0);
    check("abort_ready_high", ready_out, 1);
    repeat (2) @(negedge clk_in);
    exp_q.delete();
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    check("abort_no_done", n_done - d0, 0);
    push_msg(4'he, 4'h2, 8'h01, 8'h7f);
    set_in(4'he, 4'h2, 8'h01, 8'h7f);
    accept("post_abort", t0);
    valid_in = 1'b0;
    wait_done(t0, 3, "post_abort");
    // valid pulsed during STOP of the first byte is ignored
    @(negedge clk_in);
    e0 = n_err;
    d0 = n_done;
    push_msg(4'hd, 4'h4, 8'h55, 8'h00);
    set_in(4'hd, 4'h4, 8'h55, 8'h00);
    accept("stop_ign", t0);
    valid_in = 1'b0;
    while (cyc < t0 + 37) @(negedge clk_in);
    set_in(4'h8, 4'h1, 8'h11, 8'h22);
    @(negedge clk_in);
    valid_in = 1'b0;
    wait_done(t0, 2, "stop_ign");
    ok_tx = 1'b1;
    repeat (50) begin
      @(negedge clk_in);
      if (tx_wire_out !== 1'b1) ok_tx = 1'b0;
    end
    check("stop_ign_line_idle", ok_tx, 1);
    check("stop_ign_one_done", n_done - d0, 1);
    check("stop_ign_no_error", n_err - e0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
